// File: rtl/instmem_ctrl_pkg.sv
// ============================================================================
//  Module      : instmem_ctrl_pkg
//  Description : Shared state encoding and default widths for instmem_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 128
`endif

package instmem_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W      = `WORD_SIZE;
    localparam int unsigned DEF_BLOCK_W     = `BLOCK_SIZE;
    localparam int unsigned DEF_ALIGN_SHIFT = 7;
    localparam int unsigned DEF_MEM_LAT     = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/instmem_ctrl_if.sv
// ============================================================================
//  Module      : instmem_ctrl_if
//  Description : Read/write requester handshake bundle for instmem_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instmem_ctrl_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BLOCK_W = 128
);
    logic               rd_req;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_ack;
    logic [BLOCK_W-1:0] rd_data;
    logic               wr_req;
    logic [ADDR_W-1:0]  wr_addr;
    logic [BLOCK_W-1:0] wr_data;
    logic               wr_ack;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_ack, rd_data, wr_ack
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_ack, rd_data, wr_ack
    );
endinterface

`default_nettype wire

// File: rtl/instmem_prefetch_buf.sv
// ============================================================================
//  Module      : instmem_prefetch_buf
//  Description : One-entry next-block buffer with tag compare for instmem_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instmem_prefetch_buf #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fill,
    input  logic               inval,
    input  logic [ADDR_W-1:0]  fill_tag,
    input  logic [BLOCK_W-1:0] fill_data,
    input  logic [ADDR_W-1:0]  lookup_addr,
    output logic               hit,
    output logic [BLOCK_W-1:0] data
);
    logic               r_valid;
    logic [ADDR_W-1:0]  r_tag;
    logic [BLOCK_W-1:0] r_data;

    // Invalidation wins: a write must never leave stale code visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (inval) begin
            r_valid <= 1'b0;
        end else if (fill) begin
            r_valid <= 1'b1;
            r_tag   <= fill_tag;
            r_data  <= fill_data;
        end
    end

    assign hit  = r_valid && (r_tag == lookup_addr);
    assign data = r_data;

endmodule

`default_nettype wire

// File: rtl/instmem_ctrl.sv
// ============================================================================
//  Module      : instmem_ctrl
//  Description : Read/write arbiter and access sequencer for the instruction
//                memory port. Optional next-block prefetch buffer enabled by
//                INSTMEM_CTRL_PREFETCH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instmem_ctrl
    import instmem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned BLOCK_W     = DEF_BLOCK_W,
    parameter int unsigned ALIGN_SHIFT = DEF_ALIGN_SHIFT,
    parameter int unsigned MEM_LAT     = DEF_MEM_LAT
) (
    input  logic               clk,
    input  logic               rst_n,
    instmem_ctrl_if.slave      bus,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_readable,
    output logic               mem_writable,
    output logic [BLOCK_W-1:0] mem_write,
    input  logic [BLOCK_W-1:0] mem_out1,
    input  logic [BLOCK_W-1:0] mem_out2,
    output logic               busy
);
    localparam logic [ADDR_W-1:0] c_align_mask =
        ~ADDR_W'((64'd1 << ALIGN_SHIFT) - 64'd1);
    localparam logic [ADDR_W-1:0] c_blk_bytes = ADDR_W'(BLOCK_W / 8);

    state_t             r_state, w_state_nxt;
    logic               r_last_rd;
    logic               r_pf_sel;
    logic [2:0]         r_wait_cnt;
    logic               r_rd_ack, r_wr_ack;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [BLOCK_W-1:0] r_mem_write, r_rd_data;

    logic               w_rd_ok, w_wr_ok, w_grant_wr, w_grant_rd;
    logic [ADDR_W-1:0]  w_rd_aligned;
    logic               w_pf_hit;
    logic [BLOCK_W-1:0] w_pf_data;

    // A requester still holds req during its own ack cycle; mask it so the
    // same request is not granted twice.
    assign w_rd_ok      = bus.rd_req & ~r_rd_ack;
    assign w_wr_ok      = bus.wr_req & ~r_wr_ack;
    assign w_grant_wr   = w_wr_ok & (~w_rd_ok | r_last_rd);
    assign w_grant_rd   = w_rd_ok & ~w_grant_wr;
    assign w_rd_aligned = bus.rd_addr & c_align_mask;

`ifdef INSTMEM_CTRL_PREFETCH_EN
    instmem_prefetch_buf #(
        .ADDR_W  (ADDR_W),
        .BLOCK_W (BLOCK_W)
    ) u_pf_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .fill        ((r_state == ST_RESP) && !r_pf_sel),
        .inval       (r_state == ST_WR_ISSUE),
        .fill_tag    (r_mem_addr + c_blk_bytes),
        .fill_data   (mem_out2),
        .lookup_addr (w_rd_aligned),
        .hit         (w_pf_hit),
        .data        (w_pf_data)
    );
`else
    logic w_unused_pf;
    assign w_unused_pf = ^mem_out2;
    assign w_pf_hit    = 1'b0;
    assign w_pf_data   = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        mem_readable = 1'b0;
        mem_writable = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_grant_wr)      w_state_nxt = ST_WR_ISSUE;
                else if (w_grant_rd) w_state_nxt = w_pf_hit ? ST_RESP : ST_RD_ISSUE;
            end
            ST_WR_ISSUE: begin
                mem_writable = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                mem_readable = 1'b1;
                w_state_nxt  = (MEM_LAT == 1) ? ST_RESP : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (r_wait_cnt == 3'd1) w_state_nxt = ST_RESP;
            end
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Acks are registered so they land in the cycle after WR_ISSUE / RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_rd   <= 1'b1;
            r_pf_sel    <= 1'b0;
            r_wait_cnt  <= 3'd0;
            r_rd_ack    <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_write <= '0;
            r_rd_data   <= '0;
        end else begin
            r_rd_ack <= (r_state == ST_RESP);
            r_wr_ack <= (r_state == ST_WR_ISSUE);
            if (r_state == ST_IDLE && w_grant_wr) begin
                r_last_rd   <= 1'b0;
                r_mem_addr  <= bus.wr_addr & c_align_mask;
                r_mem_write <= bus.wr_data;
            end else if (r_state == ST_IDLE && w_grant_rd) begin
                r_last_rd <= 1'b1;
                r_pf_sel  <= w_pf_hit;
                if (!w_pf_hit) r_mem_addr <= w_rd_aligned;
            end
            if (r_state == ST_RD_ISSUE)     r_wait_cnt <= 3'(MEM_LAT - 1);
            else if (r_state == ST_RD_WAIT) r_wait_cnt <= r_wait_cnt - 3'd1;
            if (r_state == ST_RESP) r_rd_data <= r_pf_sel ? w_pf_data : mem_out1;
        end
    end

    assign bus.rd_ack  = r_rd_ack;
    assign bus.wr_ack  = r_wr_ack;
    assign bus.rd_data = r_rd_data;
    assign mem_addr    = r_mem_addr;
    assign mem_write   = r_mem_write;

endmodule

`default_nettype wire

// File: tb/tb_instmem_ctrl.sv
// ============================================================================
//  Module      : tb_instmem_ctrl
//  Description : Directed self-checking bench; unit A (MEM_LAT=1, 16-byte
//                alignment) and unit B (MEM_LAT=3, default alignment).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instmem_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned BW = 128;
`ifdef INSTMEM_CTRL_PREFETCH_EN
    localparam int HIT_LAT = 2;
    localparam int HIT_NRD = 0;
`else
    localparam int HIT_LAT = 3;
    localparam int HIT_NRD = 1;
`endif

    logic clk = 1'b0;
    logic rst_n_a, rst_n_b;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   overlap = 0;
    logic strobe_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instmem_ctrl_if #(.ADDR_W(AW), .BLOCK_W(BW)) ifa ();
    instmem_ctrl_if #(.ADDR_W(AW), .BLOCK_W(BW)) ifb ();

    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic          mem_rd_a, mem_wr_a, mem_rd_b, mem_wr_b, busy_a, busy_b;
    logic [BW-1:0] mem_write_a, mem_write_b, out1_a, out2_a, out1_b, p0_b, p1_b;

    // 16-byte alignment on unit A so the next-block tag can match a request.
    instmem_ctrl #(.ADDR_W(AW), .BLOCK_W(BW), .ALIGN_SHIFT(4), .MEM_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .bus(ifa),
        .mem_addr(mem_addr_a), .mem_readable(mem_rd_a), .mem_writable(mem_wr_a),
        .mem_write(mem_write_a), .mem_out1(out1_a), .mem_out2(out2_a), .busy(busy_a)
    );

    instmem_ctrl #(.ADDR_W(AW), .BLOCK_W(BW), .ALIGN_SHIFT(7), .MEM_LAT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .bus(ifb),
        .mem_addr(mem_addr_b), .mem_readable(mem_rd_b), .mem_writable(mem_wr_b),
        .mem_write(mem_write_b), .mem_out1(out1_b), .mem_out2('0), .busy(busy_b)
    );

    logic [BW-1:0] mem_a [logic [AW-1:0]];

    function automatic logic [BW-1:0] pat(input logic [AW-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'h1357_9BDF + a};
    endfunction

    function automatic logic [BW-1:0] blk_a(input logic [AW-1:0] a);
        return mem_a.exists(a) ? mem_a[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        if (mem_wr_a) mem_a[mem_addr_a] = mem_write_a;
        if (mem_rd_a) begin
            out1_a <= blk_a(mem_addr_a);
            out2_a <= blk_a(mem_addr_a + 32'd16);
        end
    end

    // Three-stage pipe models the MEM_LAT=3 memory behind unit B.
    always @(posedge clk) begin
        if (mem_rd_b) p0_b <= pat(mem_addr_b);
        p1_b   <= p0_b;
        out1_b <= p1_b;
    end

    always @(negedge clk) begin
        if (mem_rd_a && mem_wr_a) overlap++;
        if (mem_rd_a || mem_wr_a) strobe_q.push_back(mem_wr_a);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xact_a(input logic is_wr, input logic [31:0] addr, input logic [127:0] wdata,
                          output logic [127:0] rdata, output int lat, output int nrd,
                          output int nwr, output logic [31:0] saddr);
        int e0;
        rdata = '0; lat = -1; nrd = 0; nwr = 0; saddr = '0;
        @(posedge clk); #1;
        if (is_wr) begin
            ifa.wr_req = 1'b1; ifa.wr_addr = addr; ifa.wr_data = wdata;
        end else begin
            ifa.rd_req = 1'b1; ifa.rd_addr = addr;
        end
        e0 = cyc + 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (mem_rd_a) begin nrd++; saddr = mem_addr_a; end
            if (mem_wr_a) begin nwr++; saddr = mem_addr_a; end
            if (is_wr ? ifa.wr_ack : ifa.rd_ack) begin
                lat   = cyc + 1 - e0;
                rdata = ifa.rd_data;
                break;
            end
        end
        @(posedge clk); #1;
        ifa.rd_req = 1'b0; ifa.wr_req = 1'b0;
    endtask

    task automatic rd_b(input logic [31:0] addr, output logic [127:0] rdata, output int lat);
        int e0;
        rdata = '0; lat = -1;
        @(posedge clk); #1;
        ifb.rd_req = 1'b1; ifb.rd_addr = addr;
        e0 = cyc + 1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ifb.rd_ack) begin lat = cyc + 1 - e0; rdata = ifb.rd_data; break; end
        end
        @(posedge clk); #1;
        ifb.rd_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] rd;
        logic [127:0] wdat;
        logic [31:0]  sa;
        int lat, nrd, nwr, nack;

        wdat = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        ifa.rd_req = 1'b0; ifa.wr_req = 1'b0; ifa.rd_addr = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
        ifb.rd_req = 1'b0; ifb.wr_req = 1'b0; ifb.rd_addr = '0; ifb.wr_addr = '0; ifb.wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",     busy_a, 0);
        chk("rst_strobes",  {mem_rd_a, mem_wr_a}, 0);
        chk("rst_acks",     {ifa.rd_ack, ifa.wr_ack}, 0);
        chk("rst_mem_addr", mem_addr_a, 0);
        chk("rst_mem_wr",   mem_write_a, 0);
        chk("rst_rd_data",  ifa.rd_data, 0);
        chk("rst_b_busy",   busy_b, 0);
        #1 rst_n_a = 1'b1; rst_n_b = 1'b1;

        xact_a(1'b0, 32'h0000_0085, '0, rd, lat, nrd, nwr, sa);
        chk("rd85_lat",   128'(lat), 3);
        chk("rd85_nrd",   128'(nrd), 1);
        chk("rd85_nwr",   128'(nwr), 0);
        chk("rd85_addr",  sa, 32'h80);
        chk("rd85_data",  rd, pat(32'h80));

        xact_a(1'b1, 32'h0000_0100, wdat, rd, lat, nrd, nwr, sa);
        chk("wr100_lat",  128'(lat), 2);
        chk("wr100_nwr",  128'(nwr), 1);
        chk("wr100_nrd",  128'(nrd), 0);
        chk("wr100_addr", sa, 32'h100);
        xact_a(1'b0, 32'h0000_0100, '0, rd, lat, nrd, nwr, sa);
        chk("rd100_data", rd, wdat);
        chk("rd100_lat",  128'(lat), 3);
        @(negedge clk);
        chk("idle_busy",     busy_a, 0);
        chk("idle_mem_addr", mem_addr_a, 32'h100);
        chk("idle_mem_wr",   mem_write_a, wdat);
        chk("idle_rd_data",  ifa.rd_data, wdat);

        // Both requesters held from reset: write first, then alternate.
        @(posedge clk); #1 rst_n_a = 1'b0;
        @(posedge clk); #1 rst_n_a = 1'b1;
        strobe_q.delete();
        @(posedge clk); #1;
        ifa.wr_req = 1'b1; ifa.wr_addr = 32'h300; ifa.wr_data = ~wdat;
        ifa.rd_req = 1'b1; ifa.rd_addr = 32'h40;
        nack = 0;
        for (int n = 0; n < 60 && nack < 3; n++) begin
            @(negedge clk);
            if (ifa.rd_ack || ifa.wr_ack) nack++;
        end
        @(posedge clk); #1;
        ifa.rd_req = 1'b0; ifa.wr_req = 1'b0;
        repeat (8) @(posedge clk);
        chk("rr_acks",  128'(nack), 3);
        chk("rr_count", 128'(strobe_q.size() >= 3), 1);
        chk("rr_first", 128'(strobe_q[0]), 1);
        chk("rr_second", 128'(strobe_q[1]), 0);
        chk("rr_third", 128'(strobe_q[2]), 1);

        xact_a(1'b0, 32'h0000_0080, '0, rd, lat, nrd, nwr, sa);
        chk("pf_miss_lat", 128'(lat), 3);
        xact_a(1'b0, 32'h0000_0090, '0, rd, lat, nrd, nwr, sa);
        chk("pf_next_lat",  128'(lat), 128'(HIT_LAT));
        chk("pf_next_nrd",  128'(nrd), 128'(HIT_NRD));
        chk("pf_next_data", rd, pat(32'h90));
        xact_a(1'b0, 32'h0000_0080, '0, rd, lat, nrd, nwr, sa);
        xact_a(1'b1, 32'h0000_0200, wdat, rd, lat, nrd, nwr, sa);
        xact_a(1'b0, 32'h0000_0090, '0, rd, lat, nrd, nwr, sa);
        chk("pf_inval_lat",  128'(lat), 3);
        chk("pf_inval_nrd",  128'(nrd), 1);
        chk("pf_inval_data", rd, pat(32'h90));
        chk("no_overlap", 128'(overlap), 0);

        // Unit B: reset lands in RD_WAIT.
        @(posedge clk); #1;
        ifb.rd_req = 1'b1; ifb.rd_addr = 32'h0000_01C5;
        @(negedge clk);
        @(negedge clk);
        chk("b_strobe", mem_rd_b, 1);
        chk("b_addr",   mem_addr_b, 32'h180);
        @(negedge clk);
        chk("b_wait_busy", {busy_b, mem_rd_b}, 2'b10);
        #1 rst_n_b = 1'b0; ifb.rd_req = 1'b0;
        #1;
        chk("b_abort_busy", busy_b, 0);
        chk("b_abort_addr", mem_addr_b, 0);
        chk("b_abort_strb", {mem_rd_b, mem_wr_b}, 0);
        chk("b_abort_data", ifb.rd_data, 0);
        @(negedge clk);
        rst_n_b = 1'b1;
        nack = 0;
        repeat (10) begin
            @(negedge clk);
            if (ifb.rd_ack) nack++;
        end
        chk("b_no_ack", 128'(nack), 0);
        rd_b(32'h0000_01C5, rd, lat);
        chk("b_rd_lat",  128'(lat), 5);
        chk("b_rd_data", rd, pat(32'h180));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instmem_ctrl.md
# instmem_ctrl

Sequencer and arbiter in front of the instruction memory. Shares the memory's single address/strobe port between a read requester (I-fetch refill) and a write requester (program loader). Turns each accepted request into a one-cycle memory strobe, waits a fixed access latency, then returns data or an acknowledge through a req/ack handshake. Sits between the fetch/loader logic and the instruction memory.

## Interface
- ADDR_W, 32: address width (`WORD_SIZE`).
- BLOCK_W, 128: block width (`BLOCK_SIZE`); BLOCK_W/8 bytes per block.
- ALIGN_SHIFT, 7: low address bits the memory ignores; mem_addr has them cleared.
- MEM_LAT, 1: cycles from strobe edge to valid mem_out1/mem_out2; range 1..7.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rd_req  in  1  read request; held until rd_ack
- rd_addr  in  ADDR_W  read byte address; stable while rd_req
- rd_ack  out  1  one-cycle pulse; rd_data valid this cycle
- rd_data  out  BLOCK_W  returned block
- wr_req  in  1  write request; held until wr_ack
- wr_addr  in  ADDR_W  write byte address; stable while wr_req
- wr_data  in  BLOCK_W  write block; stable while wr_req
- wr_ack  out  1  one-cycle pulse; write committed
- mem_addr  out  ADDR_W  aligned address to memory
- mem_readable  out  1  memory read strobe
- mem_writable  out  1  memory write strobe
- mem_write  out  BLOCK_W  write data to memory
- mem_out1  in  BLOCK_W  memory block at mem_addr
- mem_out2  in  BLOCK_W  memory block at mem_addr + BLOCK_W/8
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RESP.
- IDLE: arbitrate. Only one request: grant it. Both: grant the requester not granted last (1-bit round-robin pointer). After reset the pointer favours write.
- Write grant -> WR_ISSUE: mem_writable=1, mem_addr=wr_addr with low ALIGN_SHIFT bits cleared, mem_write=wr_data, for exactly one cycle. Next cycle: wr_ack=1, back to IDLE.
- Read grant -> RD_ISSUE: mem_readable=1 and aligned mem_addr for one cycle. Then RD_WAIT for MEM_LAT-1 cycles, using a 3-bit down-counter. MEM_LAT=1 skips RD_WAIT.
- Then: capture mem_out1 into rd_data and go to RESP. In RESP, rd_ack=1 for one cycle, then back to IDLE.
- rd_data holds its value until the next capture.
- Strobes are never both high. Strobes are zero outside the ISSUE states.
- mem_addr and mem_write hold their last values when idle.
- A request deasserted before its ack is a protocol violation. Behaviour is undefined, but the FSM still completes its sequence and returns to IDLE.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE; rd_ack, wr_ack, mem_readable, mem_writable, busy = 0; mem_addr, mem_write, rd_data = 0; round-robin pointer = write; prefetch buffer invalid.
- A request sampled at edge E0 in IDLE gives strobe cycle E0+1.
- Write: wr_ack in cycle E0+2.
- Read: rd_ack in cycle E0+MEM_LAT+2.
- A new request can be granted on the edge that ends the ack cycle at the earliest. Ack-to-next-strobe is 1 cycle.
- rst_n asserted mid-transaction aborts the transaction immediately: no ack is issued and strobes drop asynchronously.

## Configuration
- INSTMEM_CTRL_PREFETCH_EN defined:
  - Every read capture also stores mem_out2 in a one-entry buffer, tagged with aligned mem_addr + BLOCK_W/8.
  - A granted read whose aligned rd_addr equals a valid tag skips memory: RD_ISSUE/RD_WAIT are bypassed and rd_ack comes at E0+2.
  - Any accepted write invalidates the buffer in its WR_ISSUE cycle.
- Undefined: no buffer; every read takes the full latency.

## Structure
- Shared package/define header holds:
  - state encoding constants (3-bit);
  - the default widths, taken from the existing WORD_SIZE and BLOCK_SIZE defines.
- One natural sub-module: instmem_prefetch_buf (tag, valid, data, hit compare). It is instantiated only under INSTMEM_CTRL_PREFETCH_EN.

## Test plan
- Reset during RD_WAIT (MEM_LAT=3) -> outputs zero at once; no rd_ack after release; next read completes normally.
- Single read, rd_addr=0x0000_0085, MEM_LAT=1 -> mem_addr=0x0000_0080; mem_readable high one cycle; rd_ack at E0+3 with rd_data = memory block at 0x80.
- Single write, wr_addr=0x0000_0100, wr_data=0x0123…CDEF -> one mem_writable cycle; wr_ack at E0+2; a following read of 0x100 returns 0x0123…CDEF.
- rd_req and wr_req both high from reset for three transactions -> grant order write, read, write; strobes never overlap.
- PREFETCH_EN, read 0x80 then read 0x90 -> second rd_ack at E0+2 with no mem_readable; interposed write to 0x200 -> second read takes full latency.
